// File: rtl/id_forward_sb.sv
// ID-stage scoreboard: tracks in-flight destinations with a readiness countdown,
// selects forwarding sources and raises stall. Perf counters: ID_FORWARD_SB_PERF_EN.
module id_forward_sb #(
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned NSTAGE       = 3,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned LAT_W        = 2,
  parameter int unsigned FLUSH_STAGES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_forward_sb_issue_valid_i,
  input  logic                          id_forward_sb_issue_rd_en_i,
  input  logic [REG_IDX_W-1:0]          id_forward_sb_issue_rd_index_i,
  input  logic [LAT_W-1:0]              id_forward_sb_issue_lat_i,
  input  logic                          id_forward_sb_advance_i,
  input  logic                          id_forward_sb_flush_i,
  input  logic [NSRC-1:0]               id_forward_sb_src_en_i,
  input  logic [NSRC-1:0]               id_forward_sb_src_early_i,
  input  logic [NSRC*REG_IDX_W-1:0]     id_forward_sb_src_index_i,
  output logic [NSRC*(NSTAGE+1)-1:0]    id_forward_sb_src_sel_o,
`ifdef ID_FORWARD_SB_PERF_EN
  output logic [31:0]                   id_forward_sb_stall_cnt_o,
  output logic [31:0]                   id_forward_sb_fwd_cnt_o,
`endif
  output logic                          id_forward_sb_stall_o
);

  typedef struct packed {
    logic                 valid;
    logic                 rd_en;
    logic [REG_IDX_W-1:0] rd_index;
    logic [LAT_W-1:0]     lat;
  } entry_t;

  entry_t [NSTAGE-1:0]          stage_q, stage_d;
  logic   [NSRC-1:0][NSTAGE-1:0] hit;
  logic   [NSRC-1:0]             unready;
  logic                          issue_accept;

  // Late sources only look at stage 0; EX forwards from the older stages itself.
  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      for (int j = 0; j < int'(NSTAGE); j++) begin
        if (j == 0 || id_forward_sb_src_early_i[k]) begin
          hit[k][j] = stage_q[j].valid & stage_q[j].rd_en &
                      (stage_q[j].rd_index != '0) & id_forward_sb_src_en_i[k] &
                      (stage_q[j].rd_index ==
                       id_forward_sb_src_index_i[k*REG_IDX_W +: REG_IDX_W]);
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest hit is the one that sticks.
  always_comb begin
    id_forward_sb_src_sel_o = '0;
    unready                 = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      id_forward_sb_src_sel_o[k*(NSTAGE+1)] = 1'b1;
      for (int j = int'(NSTAGE) - 1; j >= 0; j--) begin
        if (hit[k][j]) begin
          id_forward_sb_src_sel_o[k*(NSTAGE+1) +: (NSTAGE+1)] = '0;
          id_forward_sb_src_sel_o[k*(NSTAGE+1) + j + 1]       = 1'b1;
          unready[k] = id_forward_sb_src_early_i[k] ? (stage_q[j].lat != '0)
                                                    : (stage_q[j].lat > LAT_W'(1));
        end
      end
    end
  end

  assign id_forward_sb_stall_o = |unready;
  assign issue_accept = id_forward_sb_issue_valid_i & ~id_forward_sb_stall_o &
                        id_forward_sb_advance_i & ~id_forward_sb_flush_i;

  always_comb begin
    stage_d = stage_q;
    if (id_forward_sb_advance_i) begin
      for (int j = 1; j < int'(NSTAGE); j++) begin
        stage_d[j] = stage_q[j-1];
        if (stage_q[j-1].lat != '0) stage_d[j].lat = stage_q[j-1].lat - LAT_W'(1);
      end
      stage_d[0] = '0;
      if (issue_accept) begin
        stage_d[0].valid    = 1'b1;
        stage_d[0].rd_en    = id_forward_sb_issue_rd_en_i;
        stage_d[0].rd_index = id_forward_sb_issue_rd_index_i;
        stage_d[0].lat      = id_forward_sb_issue_lat_i;
      end
    end
    if (id_forward_sb_flush_i) begin
      for (int j = 0; j < int'(NSTAGE); j++) begin
        if (j < int'(FLUSH_STAGES) ||
            (id_forward_sb_advance_i && j == int'(FLUSH_STAGES))) begin
          stage_d[j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ID_FORWARD_SB_PERF_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q, fwd_inc;

  always_comb begin
    fwd_inc = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if ((|hit[k]) && !unready[k]) fwd_inc = fwd_inc + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, id_forward_sb_stall_o};
      fwd_cnt_q   <= fwd_cnt_q + fwd_inc;
    end
  end

  assign id_forward_sb_stall_cnt_o = stall_cnt_q;
  assign id_forward_sb_fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_forward_sb.sv
// Self-checking bench for id_forward_sb: behavioural scoreboard model compared
// every cycle, plus directed literal checks from the test plan.
module tb_id_forward_sb;
  localparam int NSTAGE = 3;
  localparam int NSRC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       issue_valid = 1'b0, issue_rd_en = 1'b0;
  logic [4:0] issue_rd = '0;
  logic [1:0] issue_lat = '0;
  logic       advance = 1'b0, flush = 1'b0;
  logic [1:0] src_en = '0, src_early = '0;
  logic [9:0] src_index = '0;
  logic [7:0] sel;
  logic       stall;
`ifdef ID_FORWARD_SB_PERF_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int m_valid[NSTAGE], m_rden[NSTAGE], m_rd[NSTAGE], m_lat[NSTAGE];
  int m_stall_cnt = 0, m_fwd_cnt = 0;

  id_forward_sb dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .id_forward_sb_issue_valid_i    (issue_valid),
    .id_forward_sb_issue_rd_en_i    (issue_rd_en),
    .id_forward_sb_issue_rd_index_i (issue_rd),
    .id_forward_sb_issue_lat_i      (issue_lat),
    .id_forward_sb_advance_i        (advance),
    .id_forward_sb_flush_i          (flush),
    .id_forward_sb_src_en_i         (src_en),
    .id_forward_sb_src_early_i      (src_early),
    .id_forward_sb_src_index_i      (src_index),
    .id_forward_sb_src_sel_o        (sel),
`ifdef ID_FORWARD_SB_PERF_EN
    .id_forward_sb_stall_cnt_o      (stall_cnt),
    .id_forward_sb_fwd_cnt_o        (fwd_cnt),
`endif
    .id_forward_sb_stall_o          (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs from the stated rules: first (youngest) hit in search range wins.
  function automatic void model_out(output logic [7:0] e_sel, output logic e_stall,
                                    output int nfwd);
    e_sel = '0;
    e_stall = 1'b0;
    nfwd = 0;
    for (int k = 0; k < NSRC; k++) begin
      int w, depth, idx, need;
      w = -1;
      depth = src_early[k] ? NSTAGE : 1;
      need = src_early[k] ? 0 : 1;
      idx = int'(src_index[k*5 +: 5]);
      for (int j = 0; j < depth; j++) begin
        if (w < 0 && src_en[k] && m_valid[j] != 0 && m_rden[j] != 0 && m_rd[j] != 0 &&
            m_rd[j] == idx) w = j;
      end
      if (w < 0) e_sel[k*4] = 1'b1;
      else begin
        e_sel[k*4 + w + 1] = 1'b1;
        if (m_lat[w] > need) e_stall = 1'b1;
        else nfwd++;
      end
    end
  endfunction

  task automatic model_step();
    logic [7:0] s;
    logic st;
    int nf;
    bit acc;
    if (!rst_n) begin
      for (int j = 0; j < NSTAGE; j++) begin
        m_valid[j] = 0; m_rden[j] = 0; m_rd[j] = 0; m_lat[j] = 0;
      end
      m_stall_cnt = 0;
      m_fwd_cnt = 0;
      return;
    end
    model_out(s, st, nf);
    m_stall_cnt += int'(st);
    m_fwd_cnt += nf;
    acc = issue_valid && !st && advance && !flush;
    if (advance) begin
      for (int j = NSTAGE - 1; j >= 1; j--) begin
        m_valid[j] = m_valid[j-1]; m_rden[j] = m_rden[j-1]; m_rd[j] = m_rd[j-1];
        m_lat[j] = (m_lat[j-1] > 0) ? m_lat[j-1] - 1 : 0;
      end
      m_valid[0] = acc ? 1 : 0;
      m_rden[0] = acc ? int'(issue_rd_en) : 0;
      m_rd[0] = acc ? int'(issue_rd) : 0;
      m_lat[0] = acc ? int'(issue_lat) : 0;
    end
    if (flush) begin
      m_valid[0] = 0;
      if (advance && NSTAGE > 1) m_valid[1] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    logic [7:0] es;
    logic est;
    int nf;
    @(negedge clk);
    model_out(es, est, nf);
    chk("model_sel", {24'd0, sel}, {24'd0, es});
    chk("model_stall", {31'd0, stall}, {31'd0, est});
`ifdef ID_FORWARD_SB_PERF_EN
    chk("model_stall_cnt", stall_cnt, 32'(m_stall_cnt));
    chk("model_fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input bit v, input bit en, input int rd, input int lat);
    issue_valid = v;
    issue_rd_en = en;
    issue_rd = 5'(rd);
    issue_lat = 2'(lat);
  endtask

  task automatic set_src(input int k, input bit en, input bit early, input int idx);
    src_en[k] = en;
    src_early[k] = early;
    src_index[k*5 +: 5] = 5'(idx);
  endtask

  task automatic drain();
    set_issue(0, 0, 0, 0);
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    flush = 0;
    advance = 1;
    repeat (NSTAGE) tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_sel", {24'd0, sel}, 32'h11);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ALU dependence
    advance = 1;
    set_issue(1, 1, 5, 1);
    tick();
    set_issue(0, 0, 0, 0);
    set_src(0, 1, 0, 5);
    #1 chk("alu_late_sel", {28'd0, sel[3:0]}, 32'b0010);
    chk("alu_late_stall", {31'd0, stall}, 32'd0);
    set_src(0, 1, 1, 5);
    #1 chk("alu_early_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("alu_adv_sel", {28'd0, sel[3:0]}, 32'b0100);
    chk("alu_adv_stall", {31'd0, stall}, 32'd0);
    drain();

    // Load-use
    set_issue(1, 1, 6, 2);
    tick();
    set_issue(1, 1, 8, 0);
    set_src(0, 1, 0, 6);
    #1 chk("ld_stall", {31'd0, stall}, 32'd1);
    chk("ld_sel", {28'd0, sel[3:0]}, 32'b0010);
    tick();
    set_issue(0, 0, 0, 0);
    chk("ld_bubble_sel", {28'd0, sel[3:0]}, 32'b0001);
    chk("ld_bubble_stall", {31'd0, stall}, 32'd0);
    set_src(1, 1, 1, 8);
    #1 chk("ld_dropped_sel", {28'd0, sel[7:4]}, 32'b0001);
    set_src(1, 1, 1, 6);
    #1 chk("ld_early_sel", {28'd0, sel[7:4]}, 32'b0100);
    chk("ld_early_stall", {31'd0, stall}, 32'd1);
    drain();

    // Youngest wins, hold without advance
    set_issue(1, 1, 7, 1);
    tick();
    set_issue(0, 0, 0, 0);
    tick();
    set_issue(1, 1, 7, 1);
    tick();
    set_issue(0, 0, 0, 0);
    advance = 0;
    set_src(1, 1, 1, 7);
    #1 chk("young_sel", {28'd0, sel[7:4]}, 32'b0010);
    chk("young_stall", {31'd0, stall}, 32'd1);
    repeat (3) tick();
    chk("hold_sel", {28'd0, sel[7:4]}, 32'b0010);
    chk("hold_stall", {31'd0, stall}, 32'd1);
    set_src(1, 1, 0, 7);
    #1 chk("hold_late_stall", {31'd0, stall}, 32'd0);
    drain();

    // Zero index and rd_en=0
    set_issue(1, 1, 0, 0);
    tick();
    set_issue(1, 0, 9, 0);
    tick();
    set_issue(0, 0, 0, 0);
    advance = 0;
    set_src(0, 1, 1, 0);
    set_src(1, 1, 1, 9);
    #1 chk("zero_sel", {24'd0, sel}, 32'h11);
    chk("zero_stall", {31'd0, stall}, 32'd0);
    advance = 1;
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    set_issue(1, 1, 4, 0);
    tick();
    set_issue(0, 0, 0, 0);
    advance = 0;
    set_src(0, 0, 1, 4);
    #1 chk("disabled_sel", {28'd0, sel[3:0]}, 32'b0001);
    set_src(0, 1, 1, 4);
    #1 chk("enabled_sel", {28'd0, sel[3:0]}, 32'b0010);
    drain();

    // Flush with advance; issue during flush is dropped
    set_issue(1, 1, 12, 0);
    tick();
    set_issue(1, 1, 3, 1);
    tick();
    set_issue(1, 1, 11, 0);
    flush = 1;
    tick();
    flush = 0;
    advance = 0;
    set_issue(0, 0, 0, 0);
    set_src(0, 1, 1, 3);
    set_src(1, 1, 1, 11);
    #1 chk("flush_sel", {24'd0, sel}, 32'h11);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    set_src(1, 1, 1, 12);
    #1 chk("flush_old_sel", {28'd0, sel[7:4]}, 32'b1000);
    drain();

    // Asynchronous reset while stalled
    set_issue(1, 1, 5, 2);
    tick();
    set_issue(0, 0, 0, 0);
    set_src(0, 1, 0, 5);
    #1 chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_sel", {24'd0, sel}, 32'h11);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_sel", {28'd0, sel[3:0]}, 32'b0001);
    drain();

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      advance = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      for (int k = 0; k < NSRC; k++) begin
        set_src(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)));
      end
      tick();
    end
    drain();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
